// File: rtl/if_id_stage.sv
// Fetch/decode boundary register: assembles one- or two-word instructions (opcode bit 0 set => immediate follows).
// Optional IF_ID_BUBBLE_COUNT_EN adds a saturating bubble_count output.
module if_id_stage #(
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [15:0] imem_word,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] imm_out,
    output logic [31:0] pc_out,
    output logic [31:0] ret_pc_out,
    output logic        valid_out,
    output logic        imm_pending
`ifdef IF_ID_BUBBLE_COUNT_EN
    ,
    output logic [15:0] bubble_count
`endif
);

    typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_op_hold, w_op_hold_nxt;
    logic [31:0] r_pc_hold, w_pc_hold_nxt;
    logic [15:0] r_instr, w_instr_nxt;
    logic [15:0] r_imm, w_imm_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_ret_pc, w_ret_pc_nxt;
    logic        r_valid, w_valid_nxt;

    // State register and all holding/output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_OP;
            r_op_hold <= '0;
            r_pc_hold <= '0;
            r_instr   <= NOP_WORD;
            r_imm     <= '0;
            r_pc      <= '0;
            r_ret_pc  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op_hold <= w_op_hold_nxt;
            r_pc_hold <= w_pc_hold_nxt;
            r_instr   <= w_instr_nxt;
            r_imm     <= w_imm_nxt;
            r_pc      <= w_pc_nxt;
            r_ret_pc  <= w_ret_pc_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    // Next-state logic: flush beats stall
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_OP;
        end else if (!stall) begin
            case (r_state)
                S_OP:    w_state_nxt = imem_word[0] ? S_IMM : S_OP;
                S_IMM:   w_state_nxt = S_OP;
                default: w_state_nxt = S_OP;
            endcase
        end
    end

    // Output/datapath next values
    always_comb begin
        w_op_hold_nxt = r_op_hold;
        w_pc_hold_nxt = r_pc_hold;
        w_instr_nxt   = r_instr;
        w_imm_nxt     = r_imm;
        w_pc_nxt      = r_pc;
        w_ret_pc_nxt  = r_ret_pc;
        w_valid_nxt   = r_valid;
        if (flush) begin
            w_op_hold_nxt = '0;
            w_pc_hold_nxt = '0;
            w_instr_nxt   = NOP_WORD;
            w_imm_nxt     = '0;
            w_pc_nxt      = '0;
            w_ret_pc_nxt  = '0;
            w_valid_nxt   = 1'b0;
        end else if (!stall) begin
            case (r_state)
                S_OP: begin
                    if (imem_word[0]) begin
                        // Opcode of a two-word instruction: park it, keep outputs, drop valid
                        w_op_hold_nxt = imem_word;
                        w_pc_hold_nxt = pc_in;
                        w_valid_nxt   = 1'b0;
                    end else begin
                        w_instr_nxt  = imem_word;
                        w_imm_nxt    = '0;
                        w_pc_nxt     = pc_in;
                        w_ret_pc_nxt = pc_in + 32'd1;
                        w_valid_nxt  = 1'b1;
                    end
                end
                S_IMM: begin
                    w_instr_nxt  = r_op_hold;
                    w_imm_nxt    = imem_word;
                    w_pc_nxt     = r_pc_hold;
                    w_ret_pc_nxt = r_pc_hold + 32'd2;
                    w_valid_nxt  = 1'b1;
                end
                default: begin
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign instr_out   = r_instr;
    assign imm_out     = r_imm;
    assign pc_out      = r_pc;
    assign ret_pc_out  = r_ret_pc;
    assign valid_out   = r_valid;
    assign imm_pending = (r_state == S_IMM);

`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [15:0] r_bubble_cnt;
    logic        w_bubble;

    // A bubble is any unstalled edge that leaves valid_out low
    assign w_bubble = flush || (!stall && (r_state == S_OP) && imem_word[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_count = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage; expected values are hand-computed constants.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [15:0] imem_word;
    logic        stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] imm_out;
    logic [31:0] pc_out;
    logic [31:0] ret_pc_out;
    logic        valid_out;
    logic        imm_pending;
`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [15:0] bubble_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_stage #(.NOP_WORD(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .imem_word   (imem_word),
        .stall       (stall),
        .flush       (flush),
        .instr_out   (instr_out),
        .imm_out     (imm_out),
        .pc_out      (pc_out),
        .ret_pc_out  (ret_pc_out),
        .valid_out   (valid_out),
        .imm_pending (imm_pending)
`ifdef IF_ID_BUBBLE_COUNT_EN
        ,
        .bubble_count(bubble_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                           input logic [31:0] pc, input logic [31:0] ret, input logic vld,
                           input logic pend);
        chk({tag, ".instr"}, {16'h0, instr_out}, {16'h0, ins});
        chk({tag, ".imm"}, {16'h0, imm_out}, {16'h0, imm});
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".ret"}, ret_pc_out, ret);
        chk({tag, ".valid"}, {31'h0, valid_out}, {31'h0, vld});
        chk({tag, ".pend"}, {31'h0, imm_pending}, {31'h0, pend});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        pc_in = 32'h20; imem_word = 16'h1234;
        edge_(); edge_();
        chk_all("reset", 16'h0000, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // single-word
        reset = 1'b0; pc_in = 32'h20; imem_word = 16'h0A02;
        edge_();
        chk_all("single", 16'h0A02, 16'h0, 32'h20, 32'h21, 1'b1, 1'b0);

        // two-word: outputs other than valid hold the previous instruction
        pc_in = 32'h30; imem_word = 16'h4C05;
        edge_();
        chk_all("two_op", 16'h0A02, 16'h0, 32'h20, 32'h21, 1'b0, 1'b1);
        pc_in = 32'h31; imem_word = 16'hBEEF;
        edge_();
        chk_all("two_imm", 16'h4C05, 16'hBEEF, 32'h30, 32'h32, 1'b1, 1'b0);

        // stall in S_IMM for 3 cycles with word changing
        pc_in = 32'h50; imem_word = 16'h4C05;
        edge_();
        chk_all("stl_op", 16'h4C05, 16'hBEEF, 32'h30, 32'h32, 1'b0, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_word = 16'h1111 * 16'(i + 1);
            pc_in = 32'h51 + 32'(i);
            edge_();
            chk_all("stl_hold", 16'h4C05, 16'hBEEF, 32'h30, 32'h32, 1'b0, 1'b1);
        end
        stall = 1'b0; pc_in = 32'h51; imem_word = 16'h5555;
        edge_();
        chk_all("stl_rel", 16'h4C05, 16'h5555, 32'h50, 32'h52, 1'b1, 1'b0);

        // stall on a valid single-word instruction keeps it presented
        stall = 1'b1; pc_in = 32'h99; imem_word = 16'h0AA0;
        edge_();
        chk_all("stl_vld", 16'h4C05, 16'h5555, 32'h50, 32'h52, 1'b1, 1'b0);
        stall = 1'b0;

        // flush and stall together in S_IMM
        pc_in = 32'h60; imem_word = 16'h0007;
        edge_();
        chk("fl_pend0", {31'h0, imm_pending}, 32'h1);
        stall = 1'b1; flush = 1'b1; pc_in = 32'h61; imem_word = 16'hCAFE;
        edge_();
        chk_all("flush", 16'h0000, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        stall = 1'b0; flush = 1'b0; pc_in = 32'h40; imem_word = 16'h0002;
        edge_();
        chk_all("post_fl", 16'h0002, 16'h0, 32'h40, 32'h41, 1'b1, 1'b0);

        // ret_pc wraparound, single- and two-word; immediate bit 0 not interpreted
        pc_in = 32'hFFFF_FFFF; imem_word = 16'h0010;
        edge_();
        chk_all("wrap1", 16'h0010, 16'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        pc_in = 32'hFFFF_FFFE; imem_word = 16'h0003;
        edge_();
        pc_in = 32'hFFFF_FFFF; imem_word = 16'h0001;
        edge_();
        chk_all("wrap2", 16'h0003, 16'h0001, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0);

        // reset mid-S_IMM
        pc_in = 32'h70; imem_word = 16'h0009;
        edge_();
        chk("rst_mid_pend", {31'h0, imm_pending}, 32'h1);
        reset = 1'b1; pc_in = 32'h71; imem_word = 16'h7777;
        edge_();
        chk_all("rst_mid", 16'h0000, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

`ifdef IF_ID_BUBBLE_COUNT_EN
        chk("bub_rst", {16'h0, bubble_count}, 32'h0);
        pc_in = 32'h80; imem_word = 16'h0101;
        edge_();
        pc_in = 32'h81; imem_word = 16'h2222;
        edge_();
        stall = 1'b1; pc_in = 32'h82; imem_word = 16'h0303;
        edge_(); edge_();
        stall = 1'b0; flush = 1'b1;
        edge_();
        flush = 1'b0;
        chk("bub_cnt", {16'h0, bubble_count}, 32'h2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch/decode boundary register. Each cycle it takes the program counter value and the 16-bit instruction-memory word fetched at that address. It assembles one- or two-word instructions, where an opcode word with bit 0 set is followed by a 16-bit immediate word. It then presents the complete instruction, its PC and its return address to the decode stage. It sits directly downstream of the program counter and instruction memory, and honours the same stall/flush controls the PC sees.

## Interface
Parameters:
- NOP_WORD, 16'h0000, opcode driven on `instr_out` after reset/flush.

Ports (`reset`: synchronous, active-high; clock `clk`):
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  32  address of `imem_word` this cycle.
- imem_word  input  16  instruction-memory word at `pc_in`.
- stall  input  1  hold all state and outputs.
- flush  input  1  discard in-flight instruction (branch taken, INT, return).
- instr_out  output  16  opcode word to decode.
- imm_out  output  16  immediate word; 0 for single-word instructions.
- pc_out  output  32  PC of the opcode word.
- ret_pc_out  output  32  `pc_out` + instruction length in words (1 or 2), mod 2^32.
- valid_out  output  1  outputs hold a complete instruction.
- imm_pending  output  1  high while in S_IMM, so the hazard unit can stall.

## Operation
- Two-state FSM: S_OP (expect opcode) and S_IMM (expect immediate). Holding registers: `op_hold`[15:0] and `pc_hold`[31:0].
- Priority each edge: reset > flush > stall > normal.
- Reset: state=S_OP; `instr_out`=NOP_WORD; `imm_out`=0; `pc_out`=0; `ret_pc_out`=0; `valid_out`=0; holds=0; counter (if present)=0.
- Flush: same values as reset except the counter. This drops any half-assembled instruction.
- Stall: state, holds and all outputs unchanged. `imm_pending` keeps reflecting the state.
- S_OP with imem_word[0]=0 (single word): load `instr_out`=imem_word, `imm_out`=0, `pc_out`=pc_in, `ret_pc_out`=pc_in+1, `valid_out`=1. Stay in S_OP.
- S_OP with imem_word[0]=1 (two words): set `op_hold`=imem_word, `pc_hold`=pc_in, `valid_out`=0, and leave the other outputs unchanged. Go to S_IMM.
- S_IMM: load `instr_out`=op_hold, `imm_out`=imem_word, `pc_out`=pc_hold, `ret_pc_out`=pc_hold+2, `valid_out`=1. Go to S_OP. Bit 0 of the immediate word is not interpreted.
- `pc_in` is not checked for contiguity. The upstream PC must deliver pc_hold+1 in S_IMM.

## Timing
- All outputs are registered; nothing is combinational from inputs except none.
- Single-word instruction sampled at edge N is on the outputs after edge N, with `valid_out`=1 for one cycle unless stalled.
- Two-word instruction: opcode sampled at N, immediate at N+1; valid after edge N+1. `valid_out`=0 during the cycle between.
- `stall` in S_IMM holds the state; the immediate is taken at the first unstalled edge.
- `flush` and `stall` both high: flush wins.
- `ret_pc_out` wraps: pc 32'hFFFF_FFFF single-word gives 32'h0000_0000.
- Reset asserted mid-S_IMM returns to S_OP with `valid_out`=0 at the next edge.

## Configuration
- `IF_ID_BUBBLE_COUNT_EN` defined: adds output `bubble_count`[15:0]. It increments on every non-reset, non-stall edge that leaves `valid_out`=0, meaning flush edges and S_OP→S_IMM edges. It saturates at 16'hFFFF and clears only on reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- Reset: hold reset 2 cycles with pc_in=32'h20 and word=16'h1234. Required: all outputs 0, `instr_out`=NOP_WORD, `valid_out`=0.
- Single-word: pc_in=32'h20, word=16'h0A02. One edge later: `instr_out`=16'h0A02, `imm_out`=0, `pc_out`=32'h20, `ret_pc_out`=32'h21, `valid_out`=1.
- Two-word: 32'h30/16'h4C05 then 32'h31/16'hBEEF. Required: `valid_out`=0 and `imm_pending`=1 after the first edge. After the second edge: `instr_out`=16'h4C05, `imm_out`=16'hBEEF, `pc_out`=32'h30, `ret_pc_out`=32'h32.
- Stall in S_IMM: after opcode 16'h4C05, hold stall 3 cycles with word changing. Required: outputs and `imm_pending` frozen. The first unstalled word becomes `imm_out`.
- Flush in S_IMM with stall also high: next edge gives `valid_out`=0, S_OP, `instr_out`=NOP_WORD. A following single-word 16'h0002 at 32'h40 emits normally.
- With `IF_ID_BUBBLE_COUNT_EN` defined: one two-word instruction plus one flush gives `bubble_count`=2. Stalled edges do not count.
